// File: rtl/lcg_stim_gen.sv
// -----------------------------------------------------------------------------
// lcg_stim_gen
//   Run-time seedable, length-limited pseudo-random word source built on a
//   32-bit LCG (state = state*32'h41C64E6D + 32'h3039, mod 2^32). Each output
//   word is OUT_W bits wide. It is assembled from NSTEP = ceil(OUT_W/32)
//   successive LCG outputs, filled from the low slice to the high slice. The
//   top partial slice takes the low bits of the state.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   seed_load    in   IDLE only: write seed_in into the seed register
//   seed_in      in   32-bit seed
//   start        in   IDLE/DONE only: begin a run
//   abort        in   return to IDLE from any state (highest priority)
//   num_words    in   run length, 0 = unlimited, sampled on start
//   out_data     out  generated word
//   out_valid    out  out_data is valid
//   out_ready    in   consumer accepts the word
//   busy         out  generator is filling or presenting a word
//   done         out  run completed (level)
//   words_sent   out  handshakes completed in the current run (saturating)
// -----------------------------------------------------------------------------
module lcg_stim_gen #(
   parameter int          OUT_W        = 132,
   parameter int          CNT_W        = 32,
   parameter logic [31:0] SEED_DEFAULT = 32'd951948522
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_load,
   input  logic [31:0]      seed_in,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_words,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] words_sent
);

   localparam int NSTEP = (OUT_W + 31) / 32;
   localparam int IDX_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam int PAD_W = NSTEP * 32;

   localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(NSTEP - 1);
   localparam logic [31:0]      LCG_MUL = 32'h41C64E6D;
   localparam logic [31:0]      LCG_INC = 32'h0000_3039;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_PRESENT,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        seed_q, seed_d;
   logic [31:0]        lcg_q, lcg_d;
   logic [IDX_W-1:0]   k_q, k_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   words_q, words_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [31:0]        lcg_next;
   logic [CNT_W-1:0]   words_inc;
   logic [PAD_W-1:0]   pad_v;
   logic               run_start;

   // Truncating 32x32 multiply plus constant; wrap-around is the mod 2^32.
   assign lcg_next  = lcg_q * LCG_MUL + LCG_INC;

   // Saturating increment: only reachable in unlimited mode, where
   // generation keeps going after the counter pins at all-ones.
   assign words_inc = (words_q == '1) ? words_q : words_q + CNT_W'(1);

   assign run_start = !abort && start && (state_q == ST_IDLE || state_q == ST_DONE);

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case leaves a value unassigned and no latch is inferred.
      state_d    = state_q;
      seed_d     = seed_q;
      lcg_d      = lcg_q;
      k_d        = k_q;
      len_d      = len_q;
      words_d    = words_q;
      out_data_d = out_data_q;

      // Word is built in a 32-bit aligned scratch vector so the top partial
      // slice falls out of the final truncation to OUT_W bits.
      pad_v                    = '0;
      pad_v[OUT_W-1:0]         = out_data_q;
      pad_v[{k_q, 5'd0} +: 32] = lcg_next;

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (seed_load) seed_d = seed_in;
               if (start)     state_d = ST_FILL;
            end
            ST_FILL: begin
               lcg_d      = lcg_next;
               out_data_d = pad_v[OUT_W-1:0];
               if (k_q == K_LAST) state_d = ST_PRESENT;
               else               k_d     = k_q + IDX_W'(1);
            end
            ST_PRESENT: begin
               if (out_ready) begin
                  words_d = words_inc;
                  if (len_q != '0 && words_inc == len_q) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_FILL;
                     k_d     = '0;
                  end
               end
            end
            ST_DONE: begin
               if (start) state_d = ST_FILL;
            end
            default: state_d = ST_IDLE;
         endcase

         // A seed_load in the same IDLE cycle as start seeds the run directly.
         if (run_start) begin
            lcg_d   = (state_q == ST_IDLE && seed_load) ? seed_in : seed_q;
            len_d   = num_words;
            words_d = '0;
            k_d     = '0;
         end
      end

      // Status outputs are registered copies of the next state.
      out_valid_d = (state_d == ST_PRESENT);
      busy_d      = (state_d == ST_FILL) || (state_d == ST_PRESENT);
      done_d      = (state_d == ST_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         seed_q      <= SEED_DEFAULT;
         lcg_q       <= '0;
         k_q         <= '0;
         len_q       <= '0;
         words_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         seed_q      <= seed_d;
         lcg_q       <= lcg_d;
         k_q         <= k_d;
         len_q       <= len_d;
         words_q     <= words_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign words_sent = words_q;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_lcg_stim_gen
//   Self-checking bench for lcg_stim_gen. Three instances (OUT_W = 132, 64, 36)
//   share all inputs. Expected words come from a plain-arithmetic LCG model
//   that assembles each word by shifting successive 32-bit outputs into place.
// -----------------------------------------------------------------------------
module tb_lcg_stim_gen;

   localparam logic [31:0] SEED_DEF = 32'd951948522;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        seed_load;
   logic [31:0] seed_in;
   logic        start;
   logic        abort;
   logic [31:0] num_words;
   logic        out_ready;

   logic [131:0] d_data;
   logic         d_valid, d_busy, d_done;
   logic [31:0]  d_ws;
   logic [63:0]  e_data;
   logic         e_valid, e_busy, e_done;
   logic [31:0]  e_ws;
   logic [35:0]  f_data;
   logic         f_valid, f_busy, f_done;
   logic [31:0]  f_ws;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] mstate;

   lcg_stim_gen u_dut (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
      .start(start), .abort(abort), .num_words(num_words),
      .out_data(d_data), .out_valid(d_valid), .out_ready(out_ready),
      .busy(d_busy), .done(d_done), .words_sent(d_ws)
   );

   lcg_stim_gen #(.OUT_W(64)) u_d64 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
      .start(start), .abort(abort), .num_words(num_words),
      .out_data(e_data), .out_valid(e_valid), .out_ready(out_ready),
      .busy(e_busy), .done(e_done), .words_sent(e_ws)
   );

   lcg_stim_gen #(.OUT_W(36)) u_d36 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
      .start(start), .abort(abort), .num_words(num_words),
      .out_data(f_data), .out_valid(f_valid), .out_ready(out_ready),
      .busy(f_busy), .done(f_done), .words_sent(f_ws)
   );

   // ---------------- reference model ----------------
   function automatic logic [31:0] lcg(input logic [31:0] x);
      return x * 32'd1103515245 + 32'd12345;
   endfunction

   // Next word of the given width from the model state.
   task automatic model_next(input int width, output logic [159:0] w);
      int steps;
      steps = (width + 31) / 32;
      w = '0;
      for (int s = 0; s < steps; s++) begin
         mstate = lcg(mstate);
         w = w | (160'(mstate) << (32 * s));
      end
      if (width < 160) w = w & ((160'(1) << width) - 160'(1));
   endtask

   // ---------------- helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      start = 1'b0; seed_load = 1'b0; out_ready = 1'b0; abort = 1'b1;
      cyc();
      abort = 1'b0;
   endtask

   // Cycles until the 132-bit instance shows out_valid, capped at 50.
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 0; i < 50; i++) begin
         cyc();
         lat++;
         if (d_valid) break;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; seed_load = 1'b0; seed_in = '0; start = 1'b0;
      abort = 1'b0; num_words = '0; out_ready = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      tests_run++;
      if ({d_data, d_valid, d_busy, d_done, d_ws} !== '0) begin
         tests_failed++;
         $display("FAIL reset_132: got data=%h v=%b b=%b d=%b ws=%0d, want all 0",
                  d_data, d_valid, d_busy, d_done, d_ws);
      end
      tests_run++;
      if ({e_data, e_valid, e_busy, e_done, e_ws} !== '0) begin
         tests_failed++;
         $display("FAIL reset_64: got data=%h v=%b b=%b d=%b ws=%0d, want all 0",
                  e_data, e_valid, e_busy, e_done, e_ws);
      end
      tests_run++;
      if ({f_data, f_valid, f_busy, f_done, f_ws} !== '0) begin
         tests_failed++;
         $display("FAIL reset_36: got data=%h v=%b b=%b d=%b ws=%0d, want all 0",
                  f_data, f_valid, f_busy, f_done, f_ws);
      end
   endtask

   // Start without seed_load: the run must use SEED_DEFAULT.
   task automatic test_default_seed();
      int lat;
      logic [159:0] w;
      num_words = 32'd1; out_ready = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      wait_valid(lat);
      tests_run++;
      if (lat !== 5) begin
         tests_failed++;
         $display("FAIL default_latency: got %0d cycles, want 5", lat);
      end
      mstate = SEED_DEF;
      model_next(132, w);
      tests_run++;
      if (d_data !== w[131:0]) begin
         tests_failed++;
         $display("FAIL default_word0: got %h, want %h", d_data, w[131:0]);
      end
      cyc();
      tests_run++;
      if ({d_done, d_valid, d_busy, d_ws} !== {3'b100, 32'd1}) begin
         tests_failed++;
         $display("FAIL default_done: got d=%b v=%b b=%b ws=%0d, want d=1 v=0 b=0 ws=1",
                  d_done, d_valid, d_busy, d_ws);
      end
   endtask

   task automatic test_seed0_widths();
      logic [159:0] w;
      idle_all();
      seed_load = 1'b1; seed_in = 32'd0; num_words = 32'd2; out_ready = 1'b1;
      start = 1'b1;
      cyc();                       // E0
      seed_load = 1'b0; start = 1'b0;
      cyc();                       // E1
      tests_run++;
      if (e_valid !== 1'b0 || e_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL w64_fill: got v=%b b=%b, want v=0 b=1", e_valid, e_busy);
      end
      cyc();                       // E2
      tests_run++;
      if (e_valid !== 1'b1 || e_data !== 64'hD3DC167E_00003039) begin
         tests_failed++;
         $display("FAIL w64_word0: got v=%b data=%h, want v=1 data=d3dc167e00003039",
                  e_valid, e_data);
      end
      tests_run++;
      if (f_valid !== 1'b1 || f_data !== 36'hE_00003039) begin
         tests_failed++;
         $display("FAIL w36_word0: got v=%b data=%h, want v=1 data=e00003039",
                  f_valid, f_data);
      end
      cyc();                       // E3: handshake of word0
      tests_run++;
      if (e_valid !== 1'b0 || e_ws !== 32'd1) begin
         tests_failed++;
         $display("FAIL w64_hs0: got v=%b ws=%0d, want v=0 ws=1", e_valid, e_ws);
      end
      cyc();                       // E4
      tests_run++;
      if (e_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL w64_word1_early: got v=%b, want 0", e_valid);
      end
      cyc();                       // E5
      mstate = 32'd0;
      model_next(64, w);
      model_next(64, w);
      tests_run++;
      if (e_valid !== 1'b1 || e_data !== w[63:0]) begin
         tests_failed++;
         $display("FAIL w64_word1: got v=%b data=%h, want v=1 data=%h",
                  e_valid, e_data, w[63:0]);
      end
      cyc();                       // E6: final handshake
      tests_run++;
      if ({e_done, e_valid, e_busy, e_ws} !== {3'b100, 32'd2}) begin
         tests_failed++;
         $display("FAIL w64_done: got d=%b v=%b b=%b ws=%0d, want d=1 v=0 b=0 ws=2",
                  e_done, e_valid, e_busy, e_ws);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [31:0]  s;
      logic [159:0] w0, w1;
      idle_all();
      s = $urandom;
      seed_load = 1'b1; seed_in = s; num_words = 32'd0; out_ready = 1'b0;
      start = 1'b1;
      cyc();
      seed_load = 1'b0; start = 1'b0;
      wait_valid(lat);
      mstate = s;
      model_next(132, w0);
      model_next(132, w1);
      tests_run++;
      if (d_valid !== 1'b1 || d_data !== w0[131:0]) begin
         tests_failed++;
         $display("FAIL bp_word0: got v=%b data=%h, want v=1 data=%h",
                  d_valid, d_data, w0[131:0]);
      end
      for (int i = 0; i < 10; i++) begin
         start = (i == 4);         // start while presenting must be ignored
         cyc();
         start = 1'b0;
         tests_run++;
         if ({d_valid, d_data, d_ws} !== {1'b1, w0[131:0], 32'd0}) begin
            tests_failed++;
            $display("FAIL bp_hold%0d: got v=%b data=%h ws=%0d, want v=1 data=%h ws=0",
                     i, d_valid, d_data, d_ws, w0[131:0]);
         end
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      tests_run++;
      if (d_valid !== 1'b0 || d_ws !== 32'd1) begin
         tests_failed++;
         $display("FAIL bp_release: got v=%b ws=%0d, want v=0 ws=1", d_valid, d_ws);
      end
      wait_valid(lat);
      tests_run++;
      if (lat !== 5 || d_data !== w1[131:0] || d_ws !== 32'd1) begin
         tests_failed++;
         $display("FAIL bp_word1: got lat=%0d data=%h ws=%0d, want lat=5 data=%h ws=1",
                  lat, d_data, d_ws, w1[131:0]);
      end
   endtask

   task automatic test_stream();
      int n, cnt;
      bit first, held;
      logic [131:0] hold_data;
      logic [159:0] w;
      idle_all();
      seed_load = 1'b1; seed_in = SEED_DEF; num_words = 32'd200; start = 1'b1;
      cyc();
      seed_load = 1'b0; start = 1'b0;
      mstate = SEED_DEF;
      n = 0; cnt = 0; first = 1'b1; held = 1'b0; hold_data = '0;
      while (!d_done && cnt < 5000) begin
         if (held) begin
            tests_run++;
            if (d_valid !== 1'b1 || d_data !== hold_data) begin
               tests_failed++;
               $display("FAIL stream_stall: got v=%b data=%h, want v=1 data=%h",
                        d_valid, d_data, hold_data);
            end
         end
         held = 1'b0;
         if (d_valid) begin
            if (first) begin
               first = 1'b0;
               tests_run++;
               if (cnt !== 5) begin
                  tests_failed++;
                  $display("FAIL stream_latency: got %0d cycles, want 5", cnt);
               end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_ready) begin
               model_next(132, w);
               tests_run++;
               if (d_data !== w[131:0]) begin
                  tests_failed++;
                  $display("FAIL stream_word%0d: got %h, want %h", n, d_data, w[131:0]);
               end
               n++;
            end else begin
               held = 1'b1;
               hold_data = d_data;
            end
         end else begin
            out_ready = 1'b0;
         end
         cyc();
         cnt++;
      end
      out_ready = 1'b0;
      tests_run++;
      if (n !== 200 || d_ws !== 32'd200 || d_done !== 1'b1 || d_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL stream_end: got n=%0d ws=%0d done=%b busy=%b, want 200/200/1/0",
                  n, d_ws, d_done, d_busy);
      end
   endtask

   task automatic test_abort_reset();
      int lat;
      logic [31:0]  s;
      logic [159:0] w;
      idle_all();
      s = $urandom;
      seed_load = 1'b1; seed_in = s; num_words = 32'd0; out_ready = 1'b0;
      start = 1'b1;
      cyc();                       // E0
      seed_load = 1'b0; start = 1'b0;
      cyc();                       // slice 0 written
      cyc();                       // slice 1 written, next is k=2
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      tests_run++;
      if ({d_valid, d_busy, d_done} !== 3'b000) begin
         tests_failed++;
         $display("FAIL abort_fill: got v=%b b=%b d=%b, want 000", d_valid, d_busy, d_done);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_valid(lat);
      mstate = s;
      model_next(132, w);
      tests_run++;
      if (lat !== 5 || d_data !== w[131:0]) begin
         tests_failed++;
         $display("FAIL abort_restart: got lat=%0d data=%h, want lat=5 data=%h",
                  lat, d_data, w[131:0]);
      end
      rst_n = 1'b0;                // reset while presenting
      cyc();
      tests_run++;
      if ({d_data, d_valid, d_busy, d_done, d_ws} !== '0) begin
         tests_failed++;
         $display("FAIL reset_present: got data=%h v=%b b=%b d=%b ws=%0d, want all 0",
                  d_data, d_valid, d_busy, d_done, d_ws);
      end
      rst_n = 1'b1; num_words = 32'd1; out_ready = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      wait_valid(lat);
      mstate = SEED_DEF;
      model_next(132, w);
      tests_run++;
      if (lat !== 5 || d_data !== w[131:0]) begin
         tests_failed++;
         $display("FAIL reset_seed_default: got lat=%0d data=%h, want lat=5 data=%h",
                  lat, d_data, w[131:0]);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_default_seed();
      test_seed0_widths();
      test_backpressure();
      test_stream();
      test_abort_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
